// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Purpose  : IF-stage program counter. Keeps the word-aligned fetch PC and
//            picks the next PC from reset, exception entry, exception return,
//            branch, jump, a buffered redirect, or PC+STEP. A branch/jump
//            that arrives while the pipeline is stalled is parked in a
//            pending register and applied when the stall releases. Also
//            owns the EPC register and the exception-level bit.
// Ports    : Clk, Reset (sync, active-high)
//            Stall                 - hazard hold
//            Br_take / Br_target   - taken branch from ID
//            Jmp_take / Jmp_target - taken jump / jr from ID
//            Exc_req / Exc_epc     - exception request and faulting PC
//            Eret                  - return from exception
//            PC, PC_plus, EPC      - fetch PC, PC+STEP, saved exception PC
//            Redirect, Pend, In_exc - status flags (all registered)
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
  parameter int unsigned     PC_W      = 30,
  parameter logic [PC_W-1:0] RESET_VEC = 30'h0000_0C00,
  parameter logic [PC_W-1:0] EXC_VEC   = 30'h0000_1060,
  parameter int unsigned     STEP      = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Stall,
  input  logic            Br_take,
  input  logic [PC_W-1:0] Br_target,
  input  logic            Jmp_take,
  input  logic [PC_W-1:0] Jmp_target,
  input  logic            Exc_req,
  input  logic [PC_W-1:0] Exc_epc,
  input  logic            Eret,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] PC_plus,
  output logic [PC_W-1:0] EPC,
  output logic            Redirect,
  output logic            Pend,
  output logic            In_exc
);

  localparam logic [PC_W-1:0] C_STEP = PC_W'(STEP);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
  logic            in_exc_q, in_exc_d;
  logic            redirect_q, redirect_d;

  logic [PC_W-1:0] pc_seq;
  logic            live_redir;
  logic [PC_W-1:0] live_tgt;

  // Sequential next PC; wraps silently modulo 2^PC_W.
  assign pc_seq = pc_q + C_STEP;

  // Live redirect from ID, branch has priority over jump.
  assign live_redir = Br_take | Jmp_take;
  assign live_tgt   = Br_take ? Br_target : Jmp_target;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    pend_tgt_d = pend_tgt_q;
    in_exc_d   = in_exc_q;
    redirect_d = 1'b0;

    if (Exc_req && !in_exc_q) begin
      // Exception entry ignores Stall and flushes any parked redirect.
      pc_d       = EXC_VEC;
      epc_d      = Exc_epc;
      in_exc_d   = 1'b1;
      pend_tgt_d = '0;
      state_d    = ST_RUN;
      redirect_d = 1'b1;
    end else if (Eret && in_exc_q) begin
      // Exception return also ignores Stall and flushes the parked redirect.
      pc_d       = epc_q;
      in_exc_d   = 1'b0;
      pend_tgt_d = '0;
      state_d    = ST_RUN;
      redirect_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (!Stall) begin
            if (live_redir) begin
              pc_d       = live_tgt;
              redirect_d = 1'b1;
            end else begin
              pc_d = pc_seq;
            end
          end else if (live_redir) begin
            // Park the redirect; PC stays frozen until the stall drops.
            pend_tgt_d = live_tgt;
            state_d    = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (Stall) begin
            // Latest redirect seen during the stall wins.
            if (live_redir) begin
              pend_tgt_d = live_tgt;
            end
          end else begin
            pc_d       = live_redir ? live_tgt : pend_tgt_q;
            redirect_d = 1'b1;
            pend_tgt_d = '0;
            state_d    = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      pend_tgt_q <= '0;
      in_exc_q   <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      pend_tgt_q <= pend_tgt_d;
      in_exc_q   <= in_exc_d;
      redirect_q <= redirect_d;
    end
  end

  assign PC       = pc_q;
  assign PC_plus  = pc_seq;
  assign EPC      = epc_q;
  assign Redirect = redirect_q;
  assign Pend     = (state_q == ST_HOLD);
  assign In_exc   = in_exc_q;

endmodule
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined datapath's IF stage. It holds the word-aligned PC and selects the next PC from sequential, branch, jump, exception-entry and exception-return sources. It freezes on pipeline hazards and buffers a branch or jump redirect that arrives during a stall until the stall releases. It also owns the EPC register and the exception-level bit.

## Interface
Parameters:
- PC_W, 30, word-address width; the PC represents byte address bits [PC_W+1:2], and byte bits [1:0] are implied 0.
- RESET_VEC, 30'h0000_0C00, PC value after reset (byte 0x0000_3000).
- EXC_VEC, 30'h0000_1060, exception entry PC (byte 0x0000_4180).
- STEP, 1, sequential increment in words.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- Stall  in  1  hazard hold; the PC does not advance.
- Br_take  in  1  branch taken (from ID).
- Br_target  in  PC_W  branch target.
- Jmp_take  in  1  jump or jr taken (from ID).
- Jmp_target  in  PC_W  jump target.
- Exc_req  in  1  exception request.
- Exc_epc  in  PC_W  PC of the faulting instruction.
- Eret  in  1  return from exception.
- PC  out  PC_W  current fetch PC (registered).
- PC_plus  out  PC_W  PC+STEP (combinational, modulo 2^PC_W).
- EPC  out  PC_W  saved exception PC (registered).
- Redirect  out  1  the PC was loaded from a non-sequential source on the last edge (registered).
- Pend  out  1  a redirect is buffered, awaiting stall release (registered).
- In_exc  out  1  exception level; nested exceptions are masked (registered).

## Operation
- Reset values:
  - PC=RESET_VEC
  - EPC=0
  - Pend=0 and the pending target=0
  - In_exc=0
  - Redirect=0
  - Redirect FSM in RUN
- Reset overrides all other inputs in the same cycle.
- Next-PC priority, highest first: Reset > Exc_req (only when In_exc=0) > Eret (only when In_exc=1) > live Br_take > live Jmp_take > pending target > sequential.
- Exc_req with In_exc=0:
  - PC<=EXC_VEC, EPC<=Exc_epc, In_exc<=1.
  - The pending buffer is cleared and the FSM goes to RUN.
  - This happens regardless of Stall.
- Exc_req with In_exc=1: ignored; normal selection applies.
- Eret with In_exc=1:
  - PC<=EPC, In_exc<=0.
  - Pending is cleared and the FSM goes to RUN.
  - This happens regardless of Stall.
- Eret with In_exc=0: no effect.
- Exc_req and Eret in the same cycle with In_exc=1: Eret acts and Exc_req is masked.
- Redirect FSM, states RUN and HOLD:
  - RUN, Stall=0: if Br_take, PC<=Br_target; else if Jmp_take, PC<=Jmp_target; else PC<=PC+STEP.
  - RUN, Stall=1 with Br_take or Jmp_take: latch the target by the same priority, PC held, go to HOLD.
  - RUN, Stall=1 with no redirect: PC held, stay in RUN.
  - HOLD, Stall=1: PC held. A live Br_take or Jmp_take overwrites the pending target (latest wins). Stay in HOLD.
  - HOLD, Stall=0: a live Br_take or Jmp_take target, if present, wins over the pending target; otherwise PC<=pending target. Clear pending and go to RUN.
- Pend is 1 exactly while in HOLD.
- Redirect is 1 for one cycle after any edge that loads PC from Br, Jmp, pending, EXC_VEC or EPC. It is 0 after sequential advances, holds, and reset.
- Arithmetic: PC+STEP is unsigned and wraps from all-ones to STEP-1 with no flag.

## Timing
- Single-cycle latency: inputs sampled at edge N are reflected on PC, EPC, Pend, In_exc and Redirect after edge N.
- PC_plus follows PC combinationally in the same cycle.
- Stall freezes PC, EPC and In_exc unless Exc_req or Eret acts.
- Stall does not block FSM transitions into HOLD.
- A stall lasting one cycle with a branch: PC holds for one edge and loads the target on the next edge.
- Reset asserted mid-HOLD: pending is discarded, and PC=RESET_VEC after that edge.

## Test plan
- Reset then 4 free cycles -> PC=0x0C00, then 0x0C01, 0x0C02, 0x0C03, 0x0C04; Redirect=0 throughout.
- Br_take=1, Br_target=0x0D00 with Stall=1 for 3 cycles, then Stall=0 -> Pend=1 for 3 cycles, PC held at its stall value; on release PC=0x0D00, Redirect=1 for one cycle, Pend=0.
- In HOLD (pending 0x0D00), release cycle with Jmp_take=1, Jmp_target=0x0E00 -> PC=0x0E00; pending discarded.
- Exc_req=1, Exc_epc=0x0C05 while Stall=1 and Pend=1 -> PC=0x1060, EPC=0x0C05, In_exc=1, Pend=0. A second Exc_req is then ignored. Eret -> PC=0x0C05, In_exc=0.
- PC preloaded via branch to 0x3FFF_FFFF, no stall -> next PC=0x0000_0000; PC_plus=0 while PC=all-ones.
- Reset asserted while in HOLD with Br_take=1 -> PC=0x0C00, Pend=0, Redirect=0 after the edge.
